// File: rtl/led_pattern_engine.sv
// LED bank driver: shared millisecond prescaler, free-running PWM frame counter,
// and per-channel OFF/ON/BLINK/PWM generators programmed through a small write port.

module led_cfg_regs #(
    parameter int NUM_LED    = 6,
    parameter int RST_PERIOD = 500,
    parameter int CH_W       = 3
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        cfg_we,
    input  logic [CH_W-1:0]             cfg_ch,
    input  logic [1:0]                  cfg_mode,
    input  logic [15:0]                 cfg_period,
    input  logic [7:0]                  cfg_duty,
    output logic [NUM_LED-1:0]          wr_hit,
    output logic [NUM_LED-1:0][1:0]     mode,
    output logic [NUM_LED-1:0][15:0]    period,
    output logic [NUM_LED-1:0][7:0]     duty
);
    localparam logic [1:0] MODE_BLINK = 2'd2;

    // Channel numbers at or above NUM_LED never match, so such writes fall away.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            wr_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_LED; i++) begin
                mode[i]   <= MODE_BLINK;
                period[i] <= 16'(RST_PERIOD);
                duty[i]   <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_LED; i++) begin
                if (wr_hit[i]) begin
                    mode[i]   <= cfg_mode;
                    period[i] <= cfg_period;
                    duty[i]   <= cfg_duty;
                end
            end
        end
    end
endmodule

module led_channel (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tick,
    input  logic        sync_i,
    input  logic        wr_hit,
    input  logic [1:0]  mode,
    input  logic [15:0] period,
    input  logic [7:0]  duty,
    input  logic [7:0]  pwm_cnt,
    output logic        lit_out
);
    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;

    logic [15:0] cnt;
    logic        lit;
    logic [15:0] last_cnt;

    // A zero half-period behaves as one tick.
    assign last_cnt = (period == 16'd0) ? 16'd0 : period - 16'd1;

    // A write or sync restarts the phase and beats any tick in the same cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= 16'd0;
            lit <= 1'b0;
        end else if (wr_hit || sync_i) begin
            cnt <= 16'd0;
            lit <= 1'b0;
        end else if (tick && (mode == MODE_BLINK)) begin
            if (cnt >= last_cnt) begin
                cnt <= 16'd0;
                lit <= ~lit;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    always_comb begin
        lit_out = 1'b0;
        case (mode)
            MODE_OFF:   lit_out = 1'b0;
            MODE_ON:    lit_out = 1'b1;
            MODE_BLINK: lit_out = lit;
            MODE_PWM:   lit_out = (pwm_cnt < duty);
            default:    lit_out = 1'b0;
        endcase
    end
endmodule

module led_pattern_engine #(
    parameter int NUM_LED        = 6,
    parameter int TICK_DIV       = 27000,
    parameter int RST_PERIOD     = 500,
    parameter bit LED_ACTIVE_LOW = 1'b1,
    parameter int CH_W           = 3
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [15:0]         cfg_period,
    input  logic [7:0]          cfg_duty,
    input  logic                sync_i,
    output logic                tick_o,
    output logic [NUM_LED-1:0]  led
);
    localparam int PS_W = $clog2(TICK_DIV);

    logic [PS_W-1:0]            prescaler;
    logic                       tick;
    logic [7:0]                 pwm_cnt;
    logic [NUM_LED-1:0]         wr_hit;
    logic [NUM_LED-1:0][1:0]    mode;
    logic [NUM_LED-1:0][15:0]   period;
    logic [NUM_LED-1:0][7:0]    duty;
    logic [NUM_LED-1:0]         lit_out;

    assign tick = (prescaler == PS_W'(TICK_DIV - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prescaler <= '0;
            tick_o    <= 1'b0;
            pwm_cnt   <= 8'd0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            tick_o    <= tick;
            pwm_cnt   <= pwm_cnt + 8'd1;
        end
    end

    led_cfg_regs #(
        .NUM_LED    (NUM_LED),
        .RST_PERIOD (RST_PERIOD),
        .CH_W       (CH_W)
    ) u_cfg_regs (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .wr_hit     (wr_hit),
        .mode       (mode),
        .period     (period),
        .duty       (duty)
    );

    for (genvar g = 0; g < NUM_LED; g++) begin : g_ch
        led_channel u_ch (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .tick      (tick),
            .sync_i    (sync_i),
            .wr_hit    (wr_hit[g]),
            .mode      (mode[g]),
            .period    (period[g]),
            .duty      (duty[g]),
            .pwm_cnt   (pwm_cnt),
            .lit_out   (lit_out[g])
        );
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led <= {NUM_LED{LED_ACTIVE_LOW}};
        end else begin
            led <= lit_out ^ {NUM_LED{LED_ACTIVE_LOW}};
        end
    end
endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: every cycle the LED bank and tick are compared
// against a model that derives each channel's state from elapsed ticks since its last phase clear.

module tb_led_pattern_engine;
    localparam int NUM_LED    = 6;
    localparam int TICK_DIV   = 4;
    localparam int RST_PERIOD = 3;
    localparam int CH_W       = 3;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic                cfg_we = 1'b0;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [1:0]          cfg_mode = '0;
    logic [15:0]         cfg_period = '0;
    logic [7:0]          cfg_duty = '0;
    logic                sync_i = 1'b0;
    logic                tick_o;
    logic [NUM_LED-1:0]  led;

    int errors = 0;
    int checks = 0;
    int e;
    int m_mode   [NUM_LED];
    int m_period [NUM_LED];
    int m_duty   [NUM_LED];
    int m_c0     [NUM_LED];

    led_pattern_engine #(
        .NUM_LED        (NUM_LED),
        .TICK_DIV       (TICK_DIV),
        .RST_PERIOD     (RST_PERIOD),
        .LED_ACTIVE_LOW (1'b1),
        .CH_W           (CH_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .sync_i     (sync_i),
        .tick_o     (tick_o),
        .led        (led)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, expv, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_LED; i++) begin
            m_mode[i]   = 2;
            m_period[i] = RST_PERIOD;
            m_duty[i]   = 0;
            m_c0[i]     = 0;
        end
        e = 0;
    endtask

    // LED pins after edge ee reflect the channel state left by edge ee-1.
    function automatic logic [NUM_LED-1:0] exp_led(input int ee);
        logic [NUM_LED-1:0] v;
        int s, n, eff;
        s = ee - 1;
        v = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            case (m_mode[i])
                0: v[i] = 1'b0;
                1: v[i] = 1'b1;
                2: begin
                    eff  = (m_period[i] == 0) ? 1 : m_period[i];
                    n    = s / TICK_DIV - m_c0[i] / TICK_DIV;
                    v[i] = ((n / eff) % 2) == 1;
                end
                default: v[i] = (s % 256) < m_duty[i];
            endcase
        end
        return ~v;
    endfunction

    task automatic step();
        @(posedge sys_clk);
        e++;
        @(negedge sys_clk);
        check("led", 16'(led), 16'(exp_led(e)));
        check("tick", 16'(tick_o), 16'((e % TICK_DIV) == 0));
    endtask

    task automatic do_write(input int ch, input int mode, input int period, input int duty, input bit sync);
        cfg_we     = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = 16'(period);
        cfg_duty   = 8'(duty);
        sync_i     = sync;
        step();
        cfg_we = 1'b0;
        sync_i = 1'b0;
        if (ch < NUM_LED) begin
            m_mode[ch]   = mode;
            m_period[ch] = period;
            m_duty[ch]   = duty;
            m_c0[ch]     = e;
        end
        if (sync) for (int i = 0; i < NUM_LED; i++) m_c0[i] = e;
    endtask

    task automatic do_sync();
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        for (int i = 0; i < NUM_LED; i++) m_c0[i] = e;
    endtask

    task automatic reset_cycles(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            check("rst_led", 16'(led), 16'h003f);
            check("rst_tick", 16'(tick_o), 16'h0000);
        end
    endtask

    task automatic run_default();
        while (e < 30) begin
            step();
            if (e == 12) check("plan_dark12", 16'(led), 16'h003f);
            if (e == 13) check("plan_low13", 16'(led), 16'h0000);
            if (e == 24) check("plan_low24", 16'(led), 16'h0000);
            if (e == 25) check("plan_high25", 16'(led), 16'h003f);
        end
    endtask

    initial begin
        int cnt, w, r;
        model_reset();
        reset_cycles(3);
        sys_rst_n = 1'b1;
        run_default();

        // ON / OFF on channel 0
        do_write(0, 1, 3, 0, 1'b0);
        repeat (20) step();
        check("on_led0", 16'(led[0]), 16'h0000);
        do_write(0, 0, 3, 0, 1'b0);
        repeat (10) step();
        check("off_led0", 16'(led[0]), 16'h0001);

        // PWM duty windows on channel 2
        do_write(2, 3, 0, 64, 1'b0);
        cnt = 0;
        repeat (256) begin step(); if (led[2] == 1'b0) cnt++; end
        check("pwm64_low", 16'(cnt), 16'd64);
        do_write(2, 3, 0, 0, 1'b0);
        cnt = 0;
        repeat (256) begin step(); if (led[2] == 1'b0) cnt++; end
        check("pwm0_low", 16'(cnt), 16'd0);
        do_write(2, 3, 0, 255, 1'b0);
        cnt = 0;
        repeat (256) begin step(); if (led[2] == 1'b1) cnt++; end
        check("pwm255_high", 16'(cnt), 16'd1);

        // Period 0 written on a tick edge: no toggle on that tick, then one per tick
        while (((e + 1) % TICK_DIV) != 0) step();
        do_write(1, 2, 0, 0, 1'b0);
        w = e;
        while (e < w + 4) step();
        check("p0_hold", 16'(led[1]), 16'h0001);
        step();
        check("p0_toggle", 16'(led[1]), 16'h0000);
        repeat (4) step();
        check("p0_toggle2", 16'(led[1]), 16'h0001);

        // Stagger three channels, then realign them
        do_write(3, 2, 2, 0, 1'b0);
        repeat (3) step();
        do_write(4, 2, 2, 0, 1'b0);
        repeat (5) step();
        do_write(5, 2, 2, 0, 1'b0);
        repeat (2) step();
        do_sync();
        repeat (20) step();

        // Invalid channel, then write combined with sync
        do_write(7, 1, 1, 255, 1'b0);
        repeat (10) step();
        do_write(2, 2, 1, 0, 1'b1);
        repeat (10) step();

        // Randomized traffic
        repeat (800) begin
            r = $urandom_range(0, 9);
            if (r == 0)
                do_write($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 4),
                         $urandom_range(0, 255), ($urandom_range(0, 3) == 0));
            else if (r == 1)
                do_sync();
            else
                step();
        end

        // Reset between edges takes effect at once
        #1 sys_rst_n = 1'b0;
        #1;
        check("async_rst_led", 16'(led), 16'h003f);
        check("async_rst_tick", 16'(tick_o), 16'h0000);
        reset_cycles(2);
        model_reset();
        sys_rst_n = 1'b1;
        run_default();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
